// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with integrated control decode, valid/ready handshake and registered result.
// Define ALU_EXEC_MUL_EN to build in the iterative shift-add multiplier (MUL state); otherwise MUL decodes as illegal.
module alu_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       funct,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_ctrl,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [3:0] {
    C_AND = 4'b0000,
    C_OR  = 4'b0001,
    C_ADD = 4'b0010,
    C_SLT = 4'b0011,
    C_MUL = 4'b0100,
    C_XOR = 4'b0101,
    C_SLL = 4'b0110,
    C_SUB = 4'b1010,
    C_ILL = 4'b1111
  } ctrl_e;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  ctrl_e            dec_ctrl;
  logic [WIDTH-1:0] dec_res;
  logic             accept;
  logic             busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctrl = C_ILL;
    case (alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b10: begin
        case (funct)
          4'b0000: dec_ctrl = C_AND;
          4'b0001: dec_ctrl = C_OR;
          4'b0010: dec_ctrl = C_ADD;
          4'b0011: dec_ctrl = C_SUB;
          4'b0100: dec_ctrl = C_SLT;
          4'b0110: dec_ctrl = C_XOR;
          4'b0111: dec_ctrl = C_SLL;
          default: dec_ctrl = C_ILL;
        endcase
      end
      default: if (MUL_EN && opcode == 4'b0110) dec_ctrl = C_MUL;
    endcase
  end

  always_comb begin
    dec_res = '0;
    case (dec_ctrl)
      C_AND:   dec_res = op_a & op_b;
      C_OR:    dec_res = op_a | op_b;
      C_ADD:   dec_res = op_a + op_b;
      C_SUB:   dec_res = op_a - op_b;
      C_SLT:   dec_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_XOR:   dec_res = op_a ^ op_b;
      C_SLL:   dec_res = op_a << op_b[SHAMT_W-1:0];
      default: dec_res = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [SHAMT_W-1:0] cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && dec_ctrl == C_MUL) state_nxt = S_MUL;
      S_MUL:   if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state == S_MUL);
  assign mul_done = busy && (cnt == SHAMT_W'(WIDTH-1));
  // Multiplicand walks left while the multiplier walks right, so bit 0 always gates the add.
  assign mul_prod = acc + ({WIDTH{mplier[0]}} & mcand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_nxt;
      if (busy) begin
        acc    <= mul_prod;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end else if (accept && dec_ctrl == C_MUL) begin
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
        cnt    <= '0;
      end
    end
  end
`else
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      alu_ctrl  <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_prod;
      alu_ctrl  <= C_MUL;
      zero      <= (mul_prod == '0);
      illegal   <= 1'b0;
    end else if (accept && dec_ctrl != C_MUL) begin
      out_valid <= 1'b1;
      result    <= dec_res;
      alu_ctrl  <= dec_ctrl;
      zero      <= (dec_res == '0);
      illegal   <= (dec_ctrl == C_ILL);
    end else if (out_ready || accept) begin
      // Drained, or a MUL was accepted: nothing valid until the product lands.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, hand sequences, random ops vs arithmetic model.
module tb_alu_exec_unit;
  localparam int W = 16;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   alu_op;
  logic [3:0]   funct, opcode, alu_ctrl;
  logic [W-1:0] op_a, op_b, result;
  logic         zero, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opcode(opcode), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_ctrl(alu_ctrl), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the decoded operation.
  function automatic void model(input logic [1:0] op, input logic [3:0] f, input logic [3:0] opc,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [3:0] c, output int lat);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint m  = longint'(1) << W;
    longint sa = a[W-1] ? ua - m : ua;
    longint sb = b[W-1] ? ub - m : ub;
    r = '0; c = 4'b1111; lat = 0;
    if (op == 2'd0) begin
      c = 4'b0010; r = W'((ua + ub) % m);
    end else if (op == 2'd1) begin
      c = 4'b1010; r = W'((ua - ub + m) % m);
    end else if (op == 2'd2) begin
      case (f)
        4'd0: begin c = 4'b0000; r = a & b; end
        4'd1: begin c = 4'b0001; r = a | b; end
        4'd2: begin c = 4'b0010; r = W'((ua + ub) % m); end
        4'd3: begin c = 4'b1010; r = W'((ua - ub + m) % m); end
        4'd4: begin c = 4'b0011; r = (sa < sb) ? W'(1) : W'(0); end
        4'd6: begin c = 4'b0101; r = a ^ b; end
        4'd7: begin c = 4'b0110; r = W'((ua * (longint'(1) << (ub % W))) % m); end
        default: ;
      endcase
    end else if (MUL_EN && opc == 4'd6) begin
      c = 4'b0100; r = W'((ua * ub) % m); lat = W;
    end
  endfunction

  // Offer one op, wait (bounded) for accept, then wait (bounded) for the result and compare.
  // lat_exp counts clock edges after the accept edge before out_valid is seen.
  task automatic do_op(input string name, input logic [1:0] op, input logic [3:0] f, input logic [3:0] opc,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [3:0] ec, input logic ez, input logic ei,
                       input int lat_exp);
    int n = 0;
    int lat = 0;
    bit ready_seen = 0;
    alu_op = op; funct = f; opcode = opc; op_a = a; op_b = b; in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) begin
      check({name, " accept timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    alu_op = 2'($urandom); funct = 4'($urandom); opcode = 4'($urandom);
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1;
      @(posedge clk); #1; lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    if (lat_exp > 0) check({name, " in_ready during MUL"}, 64'(ready_seen), 64'd0);
    check({name, " {result,ctrl,zero,illegal,valid}"},
          64'({result, alu_ctrl, zero, illegal, out_valid}), 64'({er, ec, ez, ei, 1'b1}));
  endtask

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [3:0]   f;
    logic [3:0]   opc;
    logic [W-1:0] a, b;
    logic [W-1:0] er;
    logic [3:0]   ec;
    logic         ez, ei;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [W-1:0] er;
    logic [3:0]   ec;
    int           lat;
    logic [1:0]   rop;
    logic [3:0]   rf, ropc;
    logic [W-1:0] ra, rb;
    logic [3:0]   legal_f[7];

    vecs[0]  = '{"add overflow",  2'b10, 4'b0010, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{"branch eq",     2'b01, 4'h0,    4'h0, 16'd5,    16'd5,    16'h0000, 4'b1010, 1'b1, 1'b0};
    vecs[2]  = '{"slt neg",       2'b10, 4'b0100, 4'h0, 16'hFFFF, 16'h0001, 16'h0001, 4'b0011, 1'b0, 1'b0};
    vecs[3]  = '{"slt pos>neg",   2'b10, 4'b0100, 4'h0, 16'h0001, 16'hFFFF, 16'h0000, 4'b0011, 1'b1, 1'b0};
    vecs[4]  = '{"and",           2'b10, 4'b0000, 4'h0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{"or",            2'b10, 4'b0001, 4'h0, 16'hF0F0, 16'h0F00, 16'hFFF0, 4'b0001, 1'b0, 1'b0};
    vecs[6]  = '{"sub wrap",      2'b10, 4'b0011, 4'h0, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1'b0, 1'b0};
    vecs[7]  = '{"xor self",      2'b10, 4'b0110, 4'h0, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0101, 1'b1, 1'b0};
    vecs[8]  = '{"sll shamt trunc", 2'b10, 4'b0111, 4'h0, 16'h0001, 16'h00F3, 16'h0008, 4'b0110, 1'b0, 1'b0};
    vecs[9]  = '{"illegal f5",    2'b10, 4'b0101, 4'h0, 16'h1234, 16'h5678, 16'h0000, 4'b1111, 1'b1, 1'b1};
    vecs[10] = '{"ldst add wrap", 2'b00, 4'h0,    4'h0, 16'h8000, 16'h8000, 16'h0000, 4'b0010, 1'b1, 1'b0};
    vecs[11] = '{"illegal f8",    2'b10, 4'b1000, 4'h0, 16'h0001, 16'h0001, 16'h0000, 4'b1111, 1'b1, 1'b1};
    vecs[12] = '{"illegal op11",  2'b11, 4'h0,    4'h0, 16'h0003, 16'h0003, 16'h0000, 4'b1111, 1'b1, 1'b1};
    legal_f = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct = '0; opcode = '0; op_a = '0; op_b = '0;
    #12;
    check("reset outputs", 64'({result, alu_ctrl, zero, illegal, out_valid}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].f, vecs[i].opc, vecs[i].a, vecs[i].b,
            vecs[i].er, vecs[i].ec, vecs[i].ez, vecs[i].ei, 0);

    if (MUL_EN)
      do_op("mul 300*300", 2'b11, 4'h0, 4'b0110, 16'd300, 16'd300, 16'h5F90, 4'b0100, 1'b0, 1'b0, W);
    else
      do_op("mul disabled", 2'b11, 4'h0, 4'b0110, 16'd300, 16'd300, 16'h0000, 4'b1111, 1'b1, 1'b1, 0);

    // Backpressure: result held, next op stalls until out_ready rises.
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op("bp add 1+2", 2'b00, 4'h0, 4'h0, 16'd1, 16'd2, 16'd3, 4'b0010, 1'b0, 1'b0, 0);
    alu_op = 2'b01; op_a = 16'd9; op_b = 16'd4; in_valid = 1'b1;
    #1;
    check("bp in_ready low", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("bp held result", 64'({result, out_valid}), 64'({16'd3, 1'b1}));
    out_ready = 1'b1;
    #1;
    check("bp in_ready on drain", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp sub accepted", 64'({result, alu_ctrl, out_valid}), 64'({16'd5, 4'b1010, 1'b1}));
    @(posedge clk); #1;
    check("bp drained", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of work.
    alu_op = MUL_EN ? 2'b11 : 2'b00; opcode = 4'b0110; op_a = 16'd300; op_b = 16'd300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 64'({result, alu_ctrl, zero, illegal, out_valid}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset release ready/valid", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    do_op("post-reset add 2+2", 2'b00, 4'h0, 4'h0, 16'd2, 16'd2, 16'd4, 4'b0010, 1'b0, 1'b0, 0);

    for (int k = 0; k < 300; k++) begin
      rop  = 2'($urandom_range(0, 3));
      rf   = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 6)] : 4'($urandom);
      ropc = ($urandom_range(0, 1) != 0) ? 4'd6 : 4'($urandom);
      ra   = W'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
      model(rop, rf, ropc, ra, rb, er, ec, lat);
      do_op($sformatf("rand%0d op%0d f%0h", k, rop, rf), rop, rf, ropc, ra, rb,
            er, ec, (er == '0), (ec == 4'b1111), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU with a built-in control decoder. It accepts a decoded operation (ALUOp/Funct/opcode) plus two operands over a valid/ready handshake. Logic/arithmetic ops finish in one cycle. MUL runs iteratively. It sits between the register-read stage and writeback, replacing the separate combinational control decode + ALU pair, and adds multi-cycle MUL and backpressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥4)
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from op_b

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- alu_op  in  2  00 load/store, 01 branch, 10 R-format, 11 MUL class
- funct  in  4  R-format function
- opcode  in  4  opcode, used when alu_op=11
- op_a, op_b  in  WIDTH  operands
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- alu_ctrl  out  4  registered decoded control of the held result
- zero  out  1  result == 0
- illegal  out  1  held result came from an undefined encoding

## Operation
- Decode:
  - alu_op=00 → ADD 0010.
  - alu_op=01 → SUB 1010.
  - alu_op=10, by funct:
    - 0000 AND 0000
    - 0001 OR 0001
    - 0010 ADD 0010
    - 0011 SUB 1010
    - 0100 SLT 0011
    - 0110 XOR 0101
    - 0111 SLL 0110
  - alu_op=11 with opcode 0110 → MUL 0100.
  - Any other combination → illegal: alu_ctrl=1111, result=0, illegal=1.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - SLT: signed two's-complement compare; result 1 or 0, zero-extended.
  - SLL: op_a << op_b[SHAMT_W-1:0].
  - MUL: low WIDTH bits of op_a*op_b.
- FSM states IDLE, MUL:
  - IDLE: accept when in_valid && in_ready.
    - Non-MUL op: result/alu_ctrl/zero/illegal load at the accept edge, out_valid←1, stay IDLE.
    - MUL: latch operands, clear accumulator, cnt←0, go to MUL.
  - MUL: one shift-add step per cycle, cnt++. On the edge where cnt==WIDTH-1: load the final product into result, out_valid←1, return to IDLE.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid stays high and result is stable until out_ready.
  - out_valid && out_ready with no new accept → out_valid←0.
  - Simultaneous drain and new single-cycle accept → out_valid stays 1 with the new result.
  - A MUL accept during drain → out_valid←0 until the MUL completes.

## Timing
- Reset (asynchronous, any state, including mid-MUL):
  - state←IDLE, cnt←0, accumulator←0.
  - result=0, alu_ctrl=0000, zero=0, illegal=0, out_valid=0.
  - in_ready=1 in the first cycle after rst_n rises.
  - An in-progress MUL is discarded.
- Latency: 1 cycle for non-MUL and illegal ops. MUL: out_valid rises WIDTH cycles after the accept edge.
- Throughput: 1 op/cycle for non-MUL with out_ready=1. MUL: one per WIDTH+1 cycles.
- in_ready is 0 for the entire MUL state.
- Inputs are sampled only on the accept edge; later changes do not affect an in-flight MUL.

## Configuration
- ALU_EXEC_MUL_EN defined: MUL datapath and MUL state are compiled in, as above.
- Undefined: no MUL state or accumulator. alu_op=11/opcode=0110 decodes as illegal: 1-cycle latency, result=0, alu_ctrl=1111, illegal=1.

## Test plan
- ADD: alu_op=10, funct=0010, a=0x7FFF, b=0x0001 → one cycle later: result=0x8000, alu_ctrl=0010, zero=0, out_valid=1.
- Branch compare: alu_op=01, a=5, b=5 → result=0, zero=1, alu_ctrl=1010. Then SLT: funct=0100, a=0xFFFF, b=0x0001 → result=1.
- MUL (macro on, WIDTH=16): alu_op=11, opcode=0110, a=300, b=300 → in_ready=0 for 16 cycles; out_valid rises 16 cycles after accept; result=0x5F90, alu_ctrl=0100.
- Backpressure: out_ready=0, issue ADD 1+2 then offer SUB → result=3 held, in_ready=0, SUB not accepted. Raise out_ready → SUB accepted in the same cycle, result updates next cycle.
- Illegal and macro-off: alu_op=10, funct=0101 → illegal=1, result=0, alu_ctrl=1111, latency 1. With ALU_EXEC_MUL_EN undefined, the MUL encoding gives the same response.
- Reset mid-MUL: assert rst_n=0 five cycles into a MUL → all outputs 0 immediately. After release, in_ready=1, and a following ADD 2+2 yields 4 with latency 1.
